// File: rtl/image_sender_pkg.sv
// Shared types and constants for the image_sender frame-dump engine.
package image_sender_pkg;

  typedef enum logic [2:0] {
    RDY          = 3'd0,
    READ         = 3'd1,
    WAIT_READ    = 3'd2,
    CONVERT      = 3'd3,
    WAIT_CONVERT = 3'd4,
    SEND         = 3'd5,
    WAIT_SEND    = 3'd6,
    DONE         = 3'd7
  } state_t;

  // Byte order of one pixel record on the UART
  localparam int RED             = 0;
  localparam int GREEN           = 1;
  localparam int BLUE            = 2;
  localparam int HCNT            = 3;
  localparam int VCNT            = 4;
  localparam int BYTES_PER_PIXEL = 5;

endpackage

// File: rtl/image_sender_convert.sv
// Raw 10-bit pixel to R/G/B bytes. Simple ramp mapping; swappable for a Bayer converter.
module image_sender_convert (
  input  logic [9:0] raw,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  logic unused_raw_hi;

  assign unused_raw_hi = ^raw[9:8];
  assign red           = raw[7:0];
  assign green         = red + 8'd1;
  assign blue          = red + 8'd2;

endmodule

// File: rtl/image_sender.sv
// Frame-dump engine: reads WIDTH*HEIGHT pixels from SDRAM FIFO 2 and streams
// each as a 5-byte record (R, G, B, H_cont, V_cont) over a byte-wide UART.
module image_sender
  import image_sender_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sdram_rd2_data,
  output logic       sdram_rd2_clk,
  output logic       sdram_rd2_load,
  output logic       rdy,
  input  logic       en,
  output logic [7:0] tx_data,
  output logic       tx_enable,
  output logic       tx_clk,
  output logic       ld_tx_data,
  input  logic       tx_empty,
  output logic       READ_Request,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [15:0] h_cont, v_cont;
  logic        frame_done;
  logic [9:0]  raw;
  logic [7:0]  red, green, blue;
  logic [7:0]  red_c, green_c, blue_c;
  logic [7:0]  byte_sel;
  logic        byte_ld, pix_end, h_wrap, v_wrap;

  image_sender_convert u_convert (
    .raw   (raw),
    .red   (red_c),
    .green (green_c),
    .blue  (blue_c)
  );

  assign sdram_rd2_clk = clk;
  assign tx_clk        = clk;
  assign rdy           = (state == RDY);
  assign READ_Request  = (state == READ);
  assign tx_enable     = (state != RDY) && (state != DONE);
  assign VGA_VS        = tx_enable;

  assign byte_ld = (state == SEND) && (idx < 3'(BYTES_PER_PIXEL));
  assign pix_end = (state == SEND) && (idx == 3'(BYTES_PER_PIXEL));
  assign h_wrap  = (h_cont == 16'(WIDTH - 1));
  assign v_wrap  = (v_cont == 16'(HEIGHT - 1));
  // Line sync pulses low only on the record that finishes a line
  assign VGA_HS  = !(pix_end && h_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RDY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RDY:          if (en) state_nxt = READ;
      READ:         state_nxt = frame_done ? DONE : WAIT_READ;
      WAIT_READ:    state_nxt = CONVERT;
      CONVERT:      state_nxt = WAIT_CONVERT;
      WAIT_CONVERT: state_nxt = SEND;
      SEND:         state_nxt = byte_ld ? WAIT_SEND : READ;
      WAIT_SEND:    if (tx_empty) state_nxt = SEND;
      DONE:         state_nxt = RDY;
      default:      state_nxt = RDY;
    endcase
  end

  always_comb begin
    byte_sel = 8'd0;
    case (idx)
      3'(RED):   byte_sel = red;
      3'(GREEN): byte_sel = green;
      3'(BLUE):  byte_sel = blue;
      3'(HCNT):  byte_sel = h_cont[7:0];
      3'(VCNT):  byte_sel = v_cont[7:0];
      default:   byte_sel = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cont         <= '0;
      v_cont         <= '0;
      idx            <= '0;
      frame_done     <= 1'b0;
      raw            <= '0;
      red            <= '0;
      green          <= '0;
      blue           <= '0;
      tx_data        <= '0;
      ld_tx_data     <= 1'b0;
      sdram_rd2_load <= 1'b0;
    end else begin
      ld_tx_data     <= 1'b0;
      sdram_rd2_load <= (state == RDY) && en;
      if (state == READ && frame_done) frame_done <= 1'b0;
      if (state == WAIT_READ) raw <= sdram_rd2_data;
      if (state == WAIT_CONVERT) begin
        red   <= red_c;
        green <= green_c;
        blue  <= blue_c;
      end
      if (byte_ld) begin
        tx_data    <= byte_sel;
        ld_tx_data <= 1'b1;
        idx        <= idx + 3'd1;
      end
      if (pix_end) begin
        idx <= '0;
        if (!h_wrap) begin
          h_cont <= h_cont + 16'd1;
        end else begin
          h_cont <= '0;
          if (v_wrap) begin
            v_cont     <= '0;
            frame_done <= 1'b1;
          end else begin
            v_cont <= v_cont + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_image_sender.sv
// Directed bench for image_sender with a 10x1 frame and hand-computed records.
module tb_image_sender;

  localparam int WIDTH  = 10;
  localparam int HEIGHT = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sdram_rd2_data;
  logic       sdram_rd2_clk, sdram_rd2_load, rdy, en;
  logic [7:0] tx_data;
  logic       tx_enable, tx_clk, ld_tx_data, tx_empty;
  logic       READ_Request, VGA_HS, VGA_VS;

  int n_chk  = 0;
  int n_pass = 0;

  image_sender #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sdram_rd2_data (sdram_rd2_data),
    .sdram_rd2_clk  (sdram_rd2_clk),
    .sdram_rd2_load (sdram_rd2_load),
    .rdy            (rdy),
    .en             (en),
    .tx_data        (tx_data),
    .tx_enable      (tx_enable),
    .tx_clk         (tx_clk),
    .ld_tx_data     (ld_tx_data),
    .tx_empty       (tx_empty),
    .READ_Request   (READ_Request),
    .VGA_HS         (VGA_HS),
    .VGA_VS         (VGA_VS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a negedge in READ; leaves at the negedge after the record's
  // closing SEND (READ of the next pixel).
  task automatic do_pixel(input int i, input logic [9:0] px, input bit last, input bit stall);
    logic [7:0] exp_b [5];
    logic [7:0] r;
    r        = px[7:0];
    exp_b[0] = r;
    exp_b[1] = r + 8'd1;
    exp_b[2] = r + 8'd2;
    exp_b[3] = 8'(i);
    exp_b[4] = 8'd0;
    chk("st_read", dut.state, 32'd1);
    chk("rd_req", READ_Request, 32'd1);
    sdram_rd2_data = px;
    step; chk("st_wait_read", dut.state, 32'd2);
    chk("rd2_load_low", sdram_rd2_load, 32'd0);
    step; chk("st_convert", dut.state, 32'd3);
    step; chk("st_wait_conv", dut.state, 32'd4);
    step; chk("st_send0", dut.state, 32'd5);
    chk("red", dut.red, 32'(exp_b[0]));
    chk("green", dut.green, 32'(exp_b[1]));
    chk("blue", dut.blue, 32'(exp_b[2]));
    for (int b = 0; b < 5; b++) begin
      step; chk("st_wait_send", dut.state, 32'd6);
      chk("tx_data", tx_data, 32'(exp_b[b]));
      chk("ld_tx_data", ld_tx_data, 32'd1);
      if (stall && b == 3) begin
        tx_empty = 1'b0;
        for (int k = 0; k < 10; k++) begin
          step; chk("stall_st", dut.state, 32'd6);
          chk("stall_data", tx_data, 32'(exp_b[3]));
          chk("stall_ld", ld_tx_data, 32'd0);
        end
        tx_empty = 1'b1;
      end
      step; chk("st_send", dut.state, 32'd5);
      chk("ld_low", ld_tx_data, 32'd0);
    end
    chk("vga_hs", VGA_HS, last ? 32'd0 : 32'd1);
    step;
  endtask

  initial begin
    rst_n          = 1'b0;
    en             = 1'b0;
    tx_empty       = 1'b1;
    sdram_rd2_data = '0;
    step; step;
    chk("rst_state", dut.state, 32'd0);
    chk("rst_rdy", rdy, 32'd1);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_ld", ld_tx_data, 32'd0);
    chk("rst_vs", VGA_VS, 32'd0);
    chk("rst_tx_en", tx_enable, 32'd0);
    chk("rst_rd_req", READ_Request, 32'd0);

    // Frame 1: pixels carry their own index
    rst_n = 1'b1;
    en    = 1'b1;
    step;
    chk("start_rdy", rdy, 32'd0);
    chk("start_load", sdram_rd2_load, 32'd1);
    chk("start_vs", VGA_VS, 32'd1);
    en = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      do_pixel(i, 10'(i), i == WIDTH - 1, i == 2);
    chk("end_read", dut.state, 32'd1);
    step; chk("end_done", dut.state, 32'd7);
    chk("done_tx_en", tx_enable, 32'd0);
    chk("done_vs", VGA_VS, 32'd0);
    step; chk("end_rdy", dut.state, 32'd0);
    chk("end_rdy_out", rdy, 32'd1);
    step; step; chk("idle_rdy", dut.state, 32'd0);

    // Frame 2: byte wrap on G/B, then reset mid-record
    en = 1'b1;
    step; en = 1'b0;
    do_pixel(0, 10'h1FE, 1'b0, 1'b0);
    sdram_rd2_data = 10'd1;
    for (int k = 0; k < 5; k++) step;
    chk("mid_st", dut.state, 32'd6);
    chk("mid_hcont", dut.h_cont, 32'd1);
    chk("mid_tx", tx_data, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_state", dut.state, 32'd0);
    chk("arst_hcont", dut.h_cont, 32'd0);
    chk("arst_vcont", dut.v_cont, 32'd0);
    chk("arst_tx", tx_data, 32'd0);
    chk("arst_ld", ld_tx_data, 32'd0);
    step;
    rst_n = 1'b1;
    en    = 1'b1;
    step; en = 1'b0;
    do_pixel(0, 10'h007, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
